conf_int_mac_pipe: RTL

CONF_INT_MAC_PIPE -- requirements
Module: conf_int_mac_pipe

---
 rtl/conf_int_mac_pipe.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/conf_int_mac_pipe.sv
// Pipelined signed multiply-accumulate with optional operand LSB masking and a
// held result handshake. Define CONF_INT_MAC_SAT_EN to saturate the result instead of wrapping it.
module conf_int_mac_pipe #(
    parameter int DATA_PATH_BITWIDTH = 24,
    parameter int APX_BITS           = 8,
    parameter int ACC_LEN            = 8,
    parameter int SHIFT              = 11,
    parameter int OUT_BITWIDTH       = 32
) (
    input  logic                          clk,
    input  logic                          rstP,
    input  logic [DATA_PATH_BITWIDTH-1:0] a,
    input  logic [DATA_PATH_BITWIDTH-1:0] b,
    input  logic                          rapx,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_BITWIDTH-1:0]       p,
    output logic [2:0]                    state_out
);

    localparam int DW     = DATA_PATH_BITWIDTH;
    localparam int PROD_W = 2 * DW;
    localparam int CNT_W  = $clog2(ACC_LEN);
    localparam int ACC_W  = PROD_W + CNT_W;
    localparam int EXT_W  = ((ACC_W > OUT_BITWIDTH) ? ACC_W : OUT_BITWIDTH) + 1;

    localparam logic [DW-1:0]    APX_MASK = {DW{1'b1}} << APX_BITS;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ACC_LEN - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACC    = 3'd1,
        FLUSH1 = 3'd2,
        FLUSH2 = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:1]                vld_pipe_q, vld_pipe_d;
    logic [2:1]                last_pipe_q, last_pipe_d;
    logic signed [DW-1:0]      a_q, a_d, b_q, b_d;
    logic signed [PROD_W-1:0]  prod_q, prod_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [OUT_BITWIDTH-1:0]   p_q, p_d;
    logic                      out_valid_q, out_valid_d;

    logic                      accept;
    logic                      final_beat;
    logic signed [ACC_W-1:0]   sum;
    logic signed [EXT_W-1:0]   sum_ext;
    logic signed [EXT_W-1:0]   shifted;
    logic [OUT_BITWIDTH-1:0]   res;

    assign in_ready   = (state_q == IDLE) || (state_q == ACC);
    assign accept     = in_valid && in_ready;
    assign final_beat = in_last || (cnt_q == CNT_MAX);
    assign out_valid  = out_valid_q;
    assign p          = p_q;
    assign state_out  = state_q;

    // Final reduction: the last product is folded in combinationally so the
    // result lands in p on the same edge the accumulator clears.
    always_comb begin
        sum     = acc_q + $signed({{CNT_W{prod_q[PROD_W-1]}}, prod_q});
        sum_ext = $signed({{(EXT_W-ACC_W){sum[ACC_W-1]}}, sum});
        shifted = sum_ext >>> SHIFT;
`ifdef CONF_INT_MAC_SAT_EN
        if (shifted > $signed({{(EXT_W-OUT_BITWIDTH+1){1'b0}}, {(OUT_BITWIDTH-1){1'b1}}}))
            res = {1'b0, {(OUT_BITWIDTH-1){1'b1}}};
        else if (shifted < $signed({{(EXT_W-OUT_BITWIDTH+1){1'b1}}, {(OUT_BITWIDTH-1){1'b0}}}))
            res = {1'b1, {(OUT_BITWIDTH-1){1'b0}}};
        else
            res = OUT_BITWIDTH'(shifted);
`else
        res = OUT_BITWIDTH'(shifted);
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (accept) state_d = final_beat ? FLUSH1 : ACC;
            ACC:  if (accept && final_beat) state_d = FLUSH1;
            FLUSH1: state_d = FLUSH2;
            FLUSH2: state_d = HOLD;
            HOLD: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) cnt_d = final_beat ? '0 : cnt_q + 1'b1;
    end

    always_comb begin
        vld_pipe_d  = {vld_pipe_q[1], accept};
        last_pipe_d = {last_pipe_q[1], accept && final_beat};
        a_d         = a_q;
        b_d         = b_q;
        prod_d      = prod_q;
        acc_d       = acc_q;
        p_d         = p_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            a_d = $signed(rapx ? (a & APX_MASK) : a);
            b_d = $signed(rapx ? (b & APX_MASK) : b);
        end
        if (vld_pipe_q[1]) prod_d = a_q * b_q;
        if (vld_pipe_q[2]) begin
            if (last_pipe_q[2]) begin
                p_d         = res;
                acc_d       = '0;
                out_valid_d = 1'b1;
            end else begin
                acc_d = sum;
            end
        end
        if (state_q == HOLD && out_ready) out_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rstP) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            a_q         <= '0;
            b_q         <= '0;
            prod_q      <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
            a_q         <= a_d;
            b_q         <= b_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
